// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - mode_e       : output pattern select encodings
//   - DEF_*        : default 640x480@60 timing (25 MHz pixel from 50 MHz clock)
//   - pix_flags_t  : per-pixel flags carried down the source-latency delay line
//   - bar_rgb()    : colour-bar table, returns {r,g,b} channel enables
// ---------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        ModeExt   = 2'b00,
        ModeSolid = 2'b01,
        ModeBars  = 2'b10,
        ModeBlank = 2'b11
    } mode_e;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    typedef struct packed {
        logic        active;
        logic        hs;
        logic        vs;
        logic [10:0] x;
    } pix_flags_t;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
        logic [2:0] rgb;
        case (bar)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
// Combinational pixel-colour selection for the active area.
// Ports:
//   mode       in  2   latched pattern select (vga_pkg::mode_e)
//   solid_rgb  in  12  colour for solid mode, {r,g,b}
//   src_r/g/b  in  4   external pixel data
//   x          in  11  delayed horizontal position (selects the colour bar)
//   r/g/b      out 4   selected colour
// ---------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE
) (
    input  mode_e       mode,
    input  logic [11:0] solid_rgb,
    input  logic [3:0]  src_r,
    input  logic [3:0]  src_g,
    input  logic [3:0]  src_b,
    input  logic [10:0] x,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    localparam logic [10:0] BAR_W = 11'(H_VISIBLE / 8);

    logic [2:0] bar_mask;

    always_comb begin
        bar_mask = bar_rgb(3'(x / BAR_W));
        r = 4'h0;
        g = 4'h0;
        b = 4'h0;
        unique case (mode)
            ModeExt: begin
                r = src_r;
                g = src_g;
                b = src_b;
            end
            ModeSolid: begin
                r = solid_rgb[11:8];
                g = solid_rgb[7:4];
                b = solid_rgb[3:0];
            end
            ModeBars: begin
                r = {4{bar_mask[2]}};
                g = {4{bar_mask[1]}};
                b = {4{bar_mask[0]}};
            end
            ModeBlank: begin
            end
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing with a pixel-tick enable derived from clk_50 (no derived
// clock), a PIPE-tick flag delay matching the external pixel source latency,
// and registered sync/RGB outputs.
// Ports:
//   clk_50, rst          in   system clock, synchronous active-high reset
//   mode                 in   2   pattern select, latched at frame start
//   solid_rgb            in   12  solid-mode colour
//   src_r/g/b            in   4   external pixel data (PIPE ticks after pix_req)
//   pix_ce               out  1   pixel-tick strobe (one clk_50 cycle)
//   pix_req              out  1   current position is in the active area
//   pix_x, pix_y         out  11/10 current position
//   frame_start          out  1   pix_ce tick at position (0,0)
//   vga_r/g/b            out  4   colour
//   vga_hs, vga_vs       out  1   syncs
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned PIPE      = 1
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [11:0] solid_rgb,
    input  logic [3:0]  src_r,
    input  logic [3:0]  src_g,
    input  logic [3:0]  src_b,
    output logic        pix_ce,
    output logic        pix_req,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG_W = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END_W = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] H_LAST_W = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_VIS_W  = 10'(V_VISIBLE);
    localparam logic [9:0]  VS_BEG_W = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END_W = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]  V_LAST_W = 10'(V_TOTAL - 1);
    localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);

    if (H_VISIBLE % 8 != 0) begin : g_chk_hvis
        $error("vga_timing_gen: H_VISIBLE must be divisible by 8");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be 1..16");
    end
    if (PIPE > 7) begin : g_chk_pipe
        $error("vga_timing_gen: PIPE must be 0..7");
    end

    // Pixel-tick divider; the strobe is registered so it is low during reset
    // even when CLK_DIV=1.
    logic [4:0] div_q;
    logic       pix_ce_q;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            div_q    <= '0;
            pix_ce_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q    <= '0;
            pix_ce_q <= 1'b1;
        end else begin
            div_q    <= div_q + 5'd1;
            pix_ce_q <= 1'b0;
        end
    end

    logic [10:0] h_q;
    logic [9:0]  v_q;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (pix_ce_q) begin
            if (h_q == H_LAST_W) begin
                h_q <= '0;
                v_q <= (v_q == V_LAST_W) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_q <= h_q + 11'd1;
            end
        end
    end

    pix_flags_t cur;
    pix_flags_t dly;

    assign cur = '{
        active: (h_q < H_VIS_W) && (v_q < V_VIS_W),
        hs:     (h_q >= HS_BEG_W) && (h_q < HS_END_W),
        vs:     (v_q >= VS_BEG_W) && (v_q < VS_END_W),
        x:      h_q
    };

    assign pix_ce      = pix_ce_q;
    assign pix_req     = cur.active;
    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign frame_start = pix_ce_q && (h_q == 11'd0) && (v_q == 10'd0);

    // Flags travel alongside the external source so sync/blanking line up
    // with src data that arrives PIPE ticks after pix_req.
    if (PIPE == 0) begin : g_nopipe
        assign dly = cur;
    end else begin : g_pipe
        pix_flags_t [PIPE-1:0] pipe_q;

        always_ff @(posedge clk_50) begin
            if (rst) begin
                pipe_q <= '0;
            end else if (pix_ce_q) begin
                pipe_q[0] <= cur;
                for (int i = 1; i < PIPE; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign dly = pipe_q[PIPE-1];
    end

    // Mode changes only at frame boundaries so a frame is never mixed.
    mode_e mode_q;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            mode_q <= ModeExt;
        end else if (frame_start) begin
            mode_q <= mode_e'(mode);
        end
    end

    logic [3:0] pat_r;
    logic [3:0] pat_g;
    logic [3:0] pat_b;

    vga_pattern_gen #(
        .H_VISIBLE (H_VISIBLE)
    ) u_pattern (
        .mode      (mode_q),
        .solid_rgb (solid_rgb),
        .src_r     (src_r),
        .src_g     (src_g),
        .src_b     (src_b),
        .x         (dly.x),
        .r         (pat_r),
        .g         (pat_g),
        .b         (pat_b)
    );

    always_ff @(posedge clk_50) begin
        if (rst) begin
            vga_r  <= 4'h0;
            vga_g  <= 4'h0;
            vga_b  <= 4'h0;
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
        end else if (pix_ce_q) begin
            vga_r  <= dly.active ? pat_r : 4'h0;
            vga_g  <= dly.active ? pat_g : 4'h0;
            vga_b  <= dly.active ? pat_b : 4'h0;
            vga_hs <= dly.hs ? HS_POL : ~HS_POL;
            vga_vs <= dly.vs ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench on a scaled-down raster: 16+2+3+3 = 24 pixels per line,
// 6+1+2+1 = 10 lines per frame, CLK_DIV=2, PIPE=1, active-low syncs.
// Line = 48 clk_50 cycles, frame = 480 cycles. At a negedge where pix_ce is
// high and the position is (x,y), the outputs show pixel (x-2,y).
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [11:0] solid_rgb = 12'h000;
    logic [3:0]  src_r = 4'h0;
    logic [3:0]  src_g = 4'h0;
    logic [3:0]  src_b = 4'h0;
    logic        pix_ce;
    logic        pix_req;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        frame_start;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic [11:0] rgb;

    int n_checks = 0;
    int n_pass = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_timing_gen #(
        .H_VISIBLE (16),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_VISIBLE (6),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1),
        .CLK_DIV   (2),
        .HS_POL    (1'b0),
        .VS_POL    (1'b0),
        .PIPE      (1)
    ) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .src_r       (src_r),
        .src_g       (src_g),
        .src_b       (src_b),
        .pix_ce      (pix_ce),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs)
    );

    always #5 clk_50 = ~clk_50;

    // Advance to the next negedge where pix_ce is high at position (x,y).
    task automatic goto(input int x, input int y);
        int k;
        k = 0;
        @(negedge clk_50);
        while (!(pix_ce === 1'b1 && pix_x == 11'(x) && pix_y == 10'(y)) && k < 1200) begin
            @(negedge clk_50);
            k++;
        end
        if (k >= 1200) begin
            n_checks++;
            $display("FAIL goto(%0d,%0d): position not reached after %0d cycles, required within 1200",
                     x, y, k);
        end
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50);
            n_checks++;
            if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || rgb !== 12'h000 || frame_start !== 1'b0
                || pix_ce !== 1'b0)
                $display("FAIL reset_hold[%0d]: hs=%b vs=%b rgb=%h fs=%b ce=%b, required 1 1 000 0 0",
                         i, vga_hs, vga_vs, rgb, frame_start, pix_ce);
            else
                n_pass++;
        end
        rst = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk_50);
            cnt++;
        end while (pix_ce !== 1'b1 && cnt < 20);
        n_checks++;
        if (cnt !== 2) $display("FAIL reset_first_ce: cycles=%0d, required 2", cnt);
        else n_pass++;
        n_checks++;
        if (frame_start !== 1'b1 || pix_x !== 11'd0 || pix_y !== 10'd0)
            $display("FAIL reset_first_frame_start: fs=%b x=%0d y=%0d, required fs=1 x=0 y=0",
                     frame_start, pix_x, pix_y);
        else
            n_pass++;
    endtask

    task automatic test_line_timing();
        int cnt;
        goto(0, 1);
        cnt = 0;
        do begin
            @(negedge clk_50);
            cnt++;
        end while (!(pix_ce === 1'b1 && pix_x == 11'd0) && cnt < 200);
        n_checks++;
        if (cnt !== 48) $display("FAIL line_length: cycles=%0d, required 48", cnt);
        else n_pass++;
        cnt = 0;
        do begin
            @(negedge clk_50);
            cnt++;
        end while (pix_ce !== 1'b1 && cnt < 20);
        n_checks++;
        if (cnt !== 2) $display("FAIL pix_ce_period: cycles=%0d, required 2", cnt);
        else n_pass++;
        goto(15, 3);
        n_checks++;
        if (pix_req !== 1'b1) $display("FAIL pix_req_last_visible: got %b, required 1", pix_req);
        else n_pass++;
        goto(16, 3);
        n_checks++;
        if (pix_req !== 1'b0) $display("FAIL pix_req_front_porch: got %b, required 0", pix_req);
        else n_pass++;
        goto(0, 7);
        n_checks++;
        if (pix_req !== 1'b0) $display("FAIL pix_req_vblank: got %b, required 0", pix_req);
        else n_pass++;
    endtask

    task automatic test_hsync();
        int xs [4];
        logic exp_hs [4];
        int cnt;
        xs = '{19, 20, 22, 23};
        exp_hs = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            goto(xs[i], 1);
            n_checks++;
            if (vga_hs !== exp_hs[i])
                $display("FAIL hsync_pixel%0d: got %b, required %b", xs[i] - 2, vga_hs, exp_hs[i]);
            else
                n_pass++;
        end
        cnt = 0;
        while (vga_hs !== 1'b0 && cnt < 100) begin
            @(negedge clk_50);
            cnt++;
        end
        cnt = 0;
        while (vga_hs === 1'b0 && cnt < 100) begin
            @(negedge clk_50);
            cnt++;
        end
        n_checks++;
        if (cnt !== 6) $display("FAIL hsync_width: cycles=%0d, required 6", cnt);
        else n_pass++;
    endtask

    task automatic test_vsync();
        int xs [4];
        int ys [4];
        logic exp_vs [4];
        int cnt;
        xs = '{1, 2, 1, 2};
        ys = '{7, 7, 9, 9};
        exp_vs = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            goto(xs[i], ys[i]);
            n_checks++;
            if (vga_vs !== exp_vs[i])
                $display("FAIL vsync_at(%0d,%0d): got %b, required %b", xs[i], ys[i], vga_vs,
                         exp_vs[i]);
            else
                n_pass++;
        end
        cnt = 0;
        while (vga_vs !== 1'b0 && cnt < 1200) begin
            @(negedge clk_50);
            cnt++;
        end
        cnt = 0;
        while (vga_vs === 1'b0 && cnt < 300) begin
            @(negedge clk_50);
            cnt++;
        end
        n_checks++;
        if (cnt !== 96) $display("FAIL vsync_width: cycles=%0d, required 96", cnt);
        else n_pass++;
        goto(0, 0);
        cnt = 0;
        do begin
            @(negedge clk_50);
            cnt++;
        end while (!(pix_ce === 1'b1 && frame_start === 1'b1) && cnt < 1000);
        n_checks++;
        if (cnt !== 480) $display("FAIL frame_length: cycles=%0d, required 480", cnt);
        else n_pass++;
    endtask

    task automatic test_bars();
        int px [10];
        logic [11:0] exp_c [10];
        px = '{0, 1, 2, 4, 6, 8, 10, 12, 14, 16};
        exp_c = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F,
                  12'h000, 12'h000};
        mode = 2'b10;
        goto(0, 0);
        for (int i = 0; i < 10; i++) begin
            goto(px[i] + 2, 2);
            n_checks++;
            if (rgb !== exp_c[i])
                $display("FAIL bars_pixel%0d: rgb=%h, required %h", px[i], rgb, exp_c[i]);
            else
                n_pass++;
        end
        goto(2, 6);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL bars_vblank: rgb=%h, required 000", rgb);
        else n_pass++;
    endtask

    task automatic test_mode_switch();
        int xs [6];
        int ys [6];
        logic [11:0] exp_c [6];
        mode = 2'b00;
        src_r = 4'h5;
        src_g = 4'hA;
        src_b = 4'h3;
        goto(0, 0);
        goto(0, 3);
        mode = 2'b01;
        solid_rgb = 12'hF00;
        xs = '{6, 2, 17, 1, 2, 9};
        ys = '{3, 5, 5, 0, 0, 0};
        exp_c = '{12'h5A3, 12'h5A3, 12'h5A3, 12'h000, 12'hF00, 12'hF00};
        for (int i = 0; i < 6; i++) begin
            goto(xs[i], ys[i]);
            n_checks++;
            if (rgb !== exp_c[i])
                $display("FAIL mode_switch_at(%0d,%0d): rgb=%h, required %h", xs[i], ys[i], rgb,
                         exp_c[i]);
            else
                n_pass++;
        end
        mode = 2'b11;
        goto(5, 3);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL blank_pending: rgb=%h, required F00", rgb);
        else n_pass++;
        goto(5, 1);
        n_checks++;
        if (rgb !== 12'h000) $display("FAIL blank_mode: rgb=%h, required 000", rgb);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        int cnt;
        mode = 2'b01;
        goto(0, 0);
        goto(10, 1);
        n_checks++;
        if (rgb !== 12'hF00) $display("FAIL pre_reset_solid: rgb=%h, required F00", rgb);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk_50);
        n_checks++;
        if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || rgb !== 12'h000 || pix_ce !== 1'b0
            || frame_start !== 1'b0 || pix_x !== 11'd0 || pix_y !== 10'd0)
            $display("FAIL midline_reset: hs=%b vs=%b rgb=%h ce=%b fs=%b x=%0d y=%0d, required 1 1 000 0 0 0 0",
                     vga_hs, vga_vs, rgb, pix_ce, frame_start, pix_x, pix_y);
        else
            n_pass++;
        repeat (2) @(negedge clk_50);
        rst = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk_50);
            cnt++;
        end while (pix_ce !== 1'b1 && cnt < 20);
        n_checks++;
        if (cnt !== 2 || frame_start !== 1'b1)
            $display("FAIL midline_release: cycles=%0d fs=%b, required 2 and 1", cnt, frame_start);
        else
            n_pass++;
        cnt = 0;
        do begin
            @(negedge clk_50);
            cnt++;
        end while (!(pix_ce === 1'b1 && pix_x == 11'd0) && cnt < 200);
        n_checks++;
        if (cnt !== 48) $display("FAIL midline_next_line: cycles=%0d, required 48", cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_hsync();
        test_vsync();
        test_bars();
        test_mode_switch();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
